// File: rtl/shapool_job_loader.sv
// Serial job intake for the shapool hashing core: oversampled broadcast/daisy shift-in, commit, valid/ready hand-off.
// Optional readback of the previous broadcast job on data_out: define SHAPOOL_LOADER_READBACK_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no frame in progress, counters at 0
// S_LOAD_G | shifting broadcast bits into global_sr
// S_LOAD_D | shifting daisy bits, waiting for daisy_sel to fall
// S_COMMIT | one cycle: check bit counts, publish job or flag framing error
// S_PEND   | job_valid high, outputs frozen until job_ready
module shapool_job_loader #(
    parameter int GLOBAL_BITS = 352,
    parameter int DAISY_BITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  hwclk,
    input  logic                  reset_in,
    input  logic                  data_clk,
    input  logic                  data_in,
    input  logic                  daisy_sel,
    input  logic                  daisy_in,
    output logic                  daisy_out,
    input  logic                  job_ready,
    output logic                  job_valid,
    output logic [255:0]          job_midstate,
    output logic [95:0]           job_data,
    output logic [DAISY_BITS-1:0] nonce_prefix,
    output logic                  frame_error,
    output logic                  data_out,
    output logic                  data_out_en
);

    localparam int GW = $clog2(GLOBAL_BITS + 2);
    localparam int DW = $clog2(DAISY_BITS + 2);
    localparam logic [GW-1:0] G_FULL = GW'(GLOBAL_BITS);
    localparam logic [GW-1:0] G_SAT  = GW'(GLOBAL_BITS + 1);
    localparam logic [DW-1:0] D_FULL = DW'(DAISY_BITS);
    localparam logic [DW-1:0] D_SAT  = DW'(DAISY_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_G = 3'd1,
        S_LOAD_D = 3'd2,
        S_COMMIT = 3'd3,
        S_PEND   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] clk_sync, din_sync, sel_sync, dsy_sync;
    logic                   clk_hist, sel_hist;
    logic                   clk_s, din_s, sel_s, dsy_s;
    logic                   rise, sel_fall, g_shift, d_shift, overrun;

    logic [GLOBAL_BITS-1:0] global_sr;
    logic [DAISY_BITS-1:0]  daisy_sr, nonce_snap;
    logic [GW-1:0]          gcnt;
    logic [DW-1:0]          dcnt;

    logic in_commit, commit_ok, commit_bad, idle_err, d_count;

    always_ff @(posedge hwclk) begin
        if (reset_in) begin
            clk_sync <= '0;
            din_sync <= '0;
            sel_sync <= '0;
            dsy_sync <= '0;
            clk_hist <= 1'b0;
            sel_hist <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], data_clk};
            din_sync <= {din_sync[SYNC_STAGES-2:0], data_in};
            sel_sync <= {sel_sync[SYNC_STAGES-2:0], daisy_sel};
            dsy_sync <= {dsy_sync[SYNC_STAGES-2:0], daisy_in};
            clk_hist <= clk_s;
            sel_hist <= sel_s;
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign din_s = din_sync[SYNC_STAGES-1];
    assign sel_s = sel_sync[SYNC_STAGES-1];
    assign dsy_s = dsy_sync[SYNC_STAGES-1];

    // Edge class comes from the synced daisy_sel of the same cycle.
    assign rise     = clk_s & ~clk_hist;
    assign sel_fall = sel_hist & ~sel_s;
    assign g_shift  = rise & ~sel_s & ~job_valid;
    assign d_shift  = rise & sel_s;
    assign overrun  = rise & ~sel_s & job_valid;

    always_ff @(posedge hwclk) begin
        if (reset_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (g_shift)  state_nxt = S_LOAD_G;
            S_LOAD_G: if (d_shift)  state_nxt = S_LOAD_D;
            S_LOAD_D: if (sel_fall) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = commit_ok ? S_PEND : S_IDLE;
            S_PEND:   if (job_valid && job_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_commit  = (state == S_COMMIT);
        commit_ok  = in_commit && (gcnt == G_FULL) && (dcnt >= D_FULL);
        commit_bad = in_commit && !commit_ok;
        idle_err   = (state == S_IDLE) && sel_fall;
        d_count    = (state == S_LOAD_G) || (state == S_LOAD_D);
    end

    // Daisy bits keep moving while a job is pending so downstream devices can still load.
    always_ff @(posedge hwclk) begin
        if (reset_in) begin
            global_sr   <= '0;
            daisy_sr    <= '0;
            nonce_snap  <= '0;
            gcnt        <= '0;
            dcnt        <= '0;
            daisy_out   <= 1'b0;
            job_valid   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (g_shift) begin
                global_sr <= {global_sr[GLOBAL_BITS-2:0], din_s};
                if (gcnt != G_SAT) gcnt <= gcnt + 1'b1;
            end
            if (d_shift) begin
                daisy_sr <= {daisy_sr[DAISY_BITS-2:0], dsy_s};
                if (d_count && (dcnt != D_SAT)) dcnt <= dcnt + 1'b1;
            end
            daisy_out <= daisy_sr[DAISY_BITS-1];
            if (in_commit || idle_err) begin
                gcnt <= '0;
                dcnt <= '0;
            end
            if (commit_ok) begin
                job_valid   <= 1'b1;
                frame_error <= 1'b0;
                nonce_snap  <= daisy_sr;
            end
            if (commit_bad || idle_err || overrun) frame_error <= 1'b1;
            if (job_valid && job_ready) job_valid <= 1'b0;
        end
    end

    assign job_midstate = global_sr[GLOBAL_BITS-1:96];
    assign job_data     = global_sr[95:0];
    assign nonce_prefix = job_valid ? nonce_snap : daisy_sr;

`ifdef SHAPOOL_LOADER_READBACK_EN
    logic rb_bit;

    always_ff @(posedge hwclk) begin
        if (reset_in) begin
            rb_bit <= 1'b0;
        end else if (g_shift) begin
            rb_bit <= global_sr[GLOBAL_BITS-1];
        end
    end

    assign data_out_en = (state == S_LOAD_G);
    assign data_out    = rb_bit & data_out_en;
`else
    assign data_out    = 1'b0;
    assign data_out_en = 1'b0;
`endif

endmodule

// File: tb/tb_shapool_job_loader.sv
// Bench for shapool_job_loader: three devices in a daisy chain, directed frames, frame-level model checked every quiet cycle.
`timescale 1ns/1ps
module tb_shapool_job_loader;
    localparam int GB = 352;
    localparam int DB = 8;
    localparam int SS = 2;

    logic hwclk = 1'b0;
    logic reset_in, data_clk, data_in, daisy_sel, daisy_in0, job_ready;
    logic [2:0] job_valid, daisy_out, frame_error, data_out, data_out_en;
    logic [255:0] mid [3];
    logic [95:0]  jdata [3];
    logic [7:0]   nonce [3];

    int checks = 0;
    int failures = 0;

    // Frame-level model: bit lists in, shift-register contents and flags out.
    logic [GB-1:0] m_gsr;
    logic [7:0]    m_dsr [3];
    logic [7:0]    m_snap [3];
    int            m_gbits, m_dbits;
    bit            m_started, m_seen_d, m_pend, m_err;
`ifdef SHAPOOL_LOADER_READBACK_EN
    bit            m_rb;
`endif
    bit            busy;

    always #5 hwclk = ~hwclk;

    shapool_job_loader u0 (
        .hwclk(hwclk), .reset_in(reset_in), .data_clk(data_clk), .data_in(data_in),
        .daisy_sel(daisy_sel), .daisy_in(daisy_in0), .daisy_out(daisy_out[0]),
        .job_ready(job_ready), .job_valid(job_valid[0]), .job_midstate(mid[0]),
        .job_data(jdata[0]), .nonce_prefix(nonce[0]), .frame_error(frame_error[0]),
        .data_out(data_out[0]), .data_out_en(data_out_en[0])
    );
    shapool_job_loader u1 (
        .hwclk(hwclk), .reset_in(reset_in), .data_clk(data_clk), .data_in(data_in),
        .daisy_sel(daisy_sel), .daisy_in(daisy_out[0]), .daisy_out(daisy_out[1]),
        .job_ready(job_ready), .job_valid(job_valid[1]), .job_midstate(mid[1]),
        .job_data(jdata[1]), .nonce_prefix(nonce[1]), .frame_error(frame_error[1]),
        .data_out(data_out[1]), .data_out_en(data_out_en[1])
    );
    shapool_job_loader u2 (
        .hwclk(hwclk), .reset_in(reset_in), .data_clk(data_clk), .data_in(data_in),
        .daisy_sel(daisy_sel), .daisy_in(daisy_out[1]), .daisy_out(daisy_out[2]),
        .job_ready(job_ready), .job_valid(job_valid[2]), .job_midstate(mid[2]),
        .job_data(jdata[2]), .nonce_prefix(nonce[2]), .frame_error(frame_error[2]),
        .data_out(data_out[2]), .data_out_en(data_out_en[2])
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic model_clear();
        m_gsr = '0;
        for (int i = 0; i < 3; i++) begin
            m_dsr[i] = '0;
            m_snap[i] = '0;
        end
        m_gbits = 0;
        m_dbits = 0;
        m_started = 0;
        m_seen_d = 0;
        m_pend = 0;
        m_err = 0;
`ifdef SHAPOOL_LOADER_READBACK_EN
        m_rb = 0;
`endif
    endtask

    task automatic model_edge(input logic b);
        if (daisy_sel == 1'b0) begin
            if (m_pend) begin
                m_err = 1;
            end else begin
`ifdef SHAPOOL_LOADER_READBACK_EN
                m_rb = m_gsr[GB-1];
`endif
                m_gsr = {m_gsr[GB-2:0], b};
                if (m_gbits < GB + 1) m_gbits++;
                m_started = 1;
            end
        end else begin
            m_dsr[2] = {m_dsr[2][6:0], m_dsr[1][7]};
            m_dsr[1] = {m_dsr[1][6:0], m_dsr[0][7]};
            m_dsr[0] = {m_dsr[0][6:0], b};
            if (!m_pend && m_started) begin
                m_seen_d = 1;
                if (m_dbits < DB + 1) m_dbits++;
            end
        end
    endtask

    task automatic model_fall();
        if (m_pend) begin
        end else if (!m_started) begin
            m_err = 1;
        end else if (m_seen_d) begin
            if (m_gbits == GB && m_dbits >= DB) begin
                m_pend = 1;
                m_err = 0;
                for (int i = 0; i < 3; i++) m_snap[i] = m_dsr[i];
            end else begin
                m_err = 1;
            end
            m_started = 0;
            m_seen_d = 0;
            m_gbits = 0;
            m_dbits = 0;
        end
    endtask

    task automatic send_bit(input logic b);
        busy = 1;
        data_in = b;
        daisy_in0 = b;
        cyc(2);
        data_clk = 1'b1;
        cyc(4);
        data_clk = 1'b0;
        cyc(4);
        model_edge(b);
        busy = 0;
        cyc(2);
    endtask

    task automatic sel_set(input logic v);
        logic was;
        was = daisy_sel;
        busy = 1;
        daisy_sel = v;
        cyc(8);
        if (was && !v) model_fall();
        busy = 0;
        cyc(2);
    endtask

    task automatic send_frame(input logic [GB-1:0] g, input int gn, input logic [23:0] d, input int dn);
        sel_set(1'b0);
        for (int i = gn - 1; i >= 0; i--) send_bit(g[i]);
        sel_set(1'b1);
        for (int i = dn - 1; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic accept();
        check("valid_before_ready", job_valid[0], 1'b1);
        busy = 1;
        job_ready = 1'b1;
        cyc(1);
        check("valid_drop_after_ready", job_valid[0], 1'b0);
        job_ready = 1'b0;
        m_pend = 0;
        busy = 0;
        cyc(2);
    endtask

    always @(negedge hwclk) begin
        logic exp_do, exp_en;
        if (!busy) begin
`ifdef SHAPOOL_LOADER_READBACK_EN
            exp_en = m_started && !m_seen_d && !m_pend;
            exp_do = exp_en && m_rb;
`else
            exp_en = 1'b0;
            exp_do = 1'b0;
`endif
            check("u0_midstate", mid[0], m_gsr[GB-1:96]);
            check("u0_job_data", jdata[0], m_gsr[95:0]);
            check("u0_flags{valid,err,dout,rd,rd_en,nonce}",
                  {job_valid[0], frame_error[0], daisy_out[0], data_out[0], data_out_en[0], nonce[0]},
                  {m_pend, m_err, m_dsr[0][7], exp_do, exp_en, m_pend ? m_snap[0] : m_dsr[0]});
            for (int k = 1; k < 3; k++)
                check($sformatf("u%0d_flags{valid,err,dout,nonce}", k),
                      {job_valid[k], frame_error[k], daisy_out[k], nonce[k]},
                      {m_pend, m_err, m_dsr[k][7], m_pend ? m_snap[k] : m_dsr[k]});
        end
    end

    initial begin
        repeat (90000) @(posedge hwclk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish in its cycle budget");
    end

    initial begin
        logic [GB-1:0] g_a5, g_x, g_y, g_z, cap;
        logic [7:0] dcap;
        bit found;
        g_a5 = {44{8'hA5}};
        g_x  = {11{32'hDEADBEEF}};
        g_y  = {11{32'h0F1E2D3C}};
        g_z  = {11{32'h9A3C_5E71}};

        busy = 1;
        reset_in = 1'b1;
        data_clk = 1'b0;
        data_in = 1'b0;
        daisy_sel = 1'b0;
        daisy_in0 = 1'b0;
        job_ready = 1'b0;
        model_clear();
        cyc(3);
        reset_in = 1'b0;
        busy = 0;
        cyc(2);
        check("por_valid", job_valid, 3'b000);
        check("por_nonce", nonce[0], 8'h00);

        // Reset in the middle of a broadcast load.
        sel_set(1'b0);
        for (int i = GB - 1; i >= GB - 100; i--) send_bit(g_a5[i]);
        busy = 1;
        reset_in = 1'b1;
        cyc(3);
        reset_in = 1'b0;
        model_clear();
        busy = 0;
        cyc(2);
        check("rst_midstate", mid[0], 256'h0);
        check("rst_flags{valid,err,dout,rd,rd_en}",
              {job_valid[0], frame_error[0], daisy_out[0], data_out[0], data_out_en[0]}, 5'b0);
        send_frame(g_x, GB, 24'h00005A, 8);
        sel_set(1'b0);
        check("post_rst_valid", job_valid[0], 1'b1);
        check("post_rst_midstate_top", mid[0][255:224], 32'hDEADBEEF);
        accept();

        // Nominal frame with bounded commit latency.
        send_frame(g_a5, GB, 24'h00003C, 8);
        busy = 1;
        daisy_sel = 1'b0;
        found = 0;
        for (int i = 0; i < SS + 3; i++) begin
            @(posedge hwclk);
            #1;
            if (job_valid[0] && !found) found = 1;
        end
        check("commit_latency_valid", found, 1'b1);
        cyc(4);
        model_fall();
        busy = 0;
        cyc(50);
        check("nominal_midstate_msb", mid[0][255:248], 8'hA5);
        check("nominal_nonce", nonce[0], 8'h3C);
        check("nominal_job_data", jdata[0], {12{8'hA5}});
        check("nominal_valid_held", job_valid[0], 1'b1);

        // Broadcast edges while the job is pending.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("overrun_err", frame_error[0], 1'b1);
        check("overrun_midstate", mid[0], {32{8'hA5}});
        check("overrun_valid", job_valid[0], 1'b1);
        accept();

        // One broadcast bit short, then a good frame clears the error.
        send_frame(g_x, GB - 1, 24'h00003C, 8);
        sel_set(1'b0);
        check("short_err", frame_error[0], 1'b1);
        check("short_valid", job_valid[0], 1'b0);
        send_frame(g_y, GB, 24'h0000C3, 8);
        sel_set(1'b0);
        check("recover_err", frame_error[0], 1'b0);
        check("recover_nonce", nonce[0], 8'hC3);
        accept();

        // Daisy bits before any broadcast bits.
        sel_set(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        sel_set(1'b0);
        check("daisy_first_err", frame_error[0], 1'b1);
        check("daisy_first_valid", job_valid[0], 1'b0);

        // Three-device chain, then drain the far device while pending.
        send_frame(g_z, GB, 24'h112233, 24);
        sel_set(1'b0);
        check("chain_nonce_u0", nonce[0], 8'h33);
        check("chain_nonce_u1", nonce[1], 8'h22);
        check("chain_nonce_u2", nonce[2], 8'h11);
        check("chain_valid", job_valid, 3'b111);
        check("chain_err", frame_error[0], 1'b0);
        sel_set(1'b1);
        dcap = '0;
        for (int i = 0; i < 8; i++) begin
            dcap = {dcap[6:0], daisy_out[2]};
            send_bit(1'b0);
        end
        sel_set(1'b0);
        check("chain_u2_daisy_out", dcap, 8'h11);
        check("chain_snapshot_held", nonce[0], 8'h33);
        check("chain_drain_err", frame_error[0], 1'b0);
        accept();

`ifdef SHAPOOL_LOADER_READBACK_EN
        send_frame(g_a5, GB, 24'h000001, 8);
        sel_set(1'b0);
        accept();
        sel_set(1'b0);
        cap = '0;
        for (int i = GB - 1; i >= 0; i--) begin
            send_bit(g_z[i]);
            check("rb_en_load_g", data_out_en[0], 1'b1);
            cap = {cap[GB-2:0], data_out[0]};
        end
        check("rb_bits_hi", cap[GB-1:96], g_a5[GB-1:96]);
        check("rb_bits_lo", cap[95:0], g_a5[95:0]);
        sel_set(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(i[0]);
        check("rb_en_load_d", data_out_en[0], 1'b0);
        sel_set(1'b0);
        check("rb_en_pend", data_out_en[0], 1'b0);
        accept();
`else
        cap = '0;
        dcap = '0;
`endif

        cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
